memory_access_stage: RTL and testbench

//  MEM-stage data-memory unit; sits between the EX/MEM barrier and the MEM/WB barrier.

---
 rtl/memory_access_stage.sv | 176 +++++++++++++++++
 tb/tb_memory_access_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - MEM-stage data-memory unit with ready handshake, lane alignment and timeout
module memory_access_stage #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memAluResult,
  input  logic [31:0] memStoreData,
  input  logic        memIsMemRead,
  input  logic        memIsMemWrite,
  input  logic [2:0]  memFunct3,
  input  logic        memIsRegisterWrite,
  output logic        dmemReq,
  output logic        dmemWe,
  output logic [31:0] dmemAddr,
  output logic [31:0] dmemWdata,
  output logic [3:0]  dmemByteEnable,
  input  logic        dmemReady,
  input  logic [31:0] dmemRdata,
  output logic        memStall,
  output logic [31:0] memMemoryData,
  output logic [31:0] memExecutionData,
  output logic        memShouldUseMemoryData,
  output logic        memRegisterWriteOut,
  output logic        memAccessFault,
  output logic        memBusError
);

  localparam int CW = $clog2(MAX_WAIT) + 1;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t          state, nextState;
  logic [CW-1:0]   waitCnt;
  logic [31:0]     rdLatch;
  logic            errorFlag;

  logic            access, bothHigh, illegalF3, misaligned, fault, issue;
  logic [1:0]      k;
  logic [31:0]     shifted, loadData;
  logic [3:0]      storeBe;
  logic [31:0]     storeData;

  assign k          = memAluResult[1:0];
  assign access     = memIsMemRead ^ memIsMemWrite;
  assign bothHigh   = memIsMemRead & memIsMemWrite;

  always_comb begin
    illegalF3  = 1'b0;
    misaligned = 1'b0;
    if (memIsMemRead)
      illegalF3 = !(memFunct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else
      illegalF3 = !(memFunct3 inside {3'b000, 3'b001, 3'b010});
    if (memFunct3[1:0] == 2'b01)
      misaligned = k[0];
    else if (memFunct3[1:0] == 2'b10)
      misaligned = (k != 2'b00);
  end

  assign fault = bothHigh | (access & (illegalF3 | misaligned));
  assign issue = access & ~fault;

  // Store lane alignment: data replicated across lanes, enables pick the target bytes
  always_comb begin
    storeData = memStoreData;
    storeBe   = 4'b1111;
    case (memFunct3[1:0])
      2'b00: begin
        storeData = {4{memStoreData[7:0]}};
        storeBe   = 4'b0001 << k;
      end
      2'b01: begin
        storeData = {2{memStoreData[15:0]}};
        storeBe   = k[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        storeData = memStoreData;
        storeBe   = 4'b1111;
      end
    endcase
  end

  assign shifted = rdLatch >> {k, 3'b000};

  always_comb begin
    case (memFunct3)
      3'b000:  loadData = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  loadData = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  loadData = {24'd0, shifted[7:0]};
      3'b101:  loadData = {16'd0, shifted[15:0]};
      default: loadData = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      waitCnt   <= '0;
      rdLatch   <= '0;
      errorFlag <= 1'b0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          errorFlag <= 1'b0;
          if (issue) begin
            if (dmemReady) rdLatch <= dmemRdata;
            else           waitCnt <= CW'(1);
          end
        end
        REQ: begin
          if (dmemReady) begin
            rdLatch <= dmemRdata;
          end else if (waitCnt == CW'(MAX_WAIT - 1)) begin
            rdLatch   <= '0;
            errorFlag <= 1'b1;
          end else begin
            waitCnt <= waitCnt + CW'(1);
          end
        end
        default: waitCnt <= '0;
      endcase
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (issue) nextState = dmemReady ? DONE : REQ;
      REQ:     if (dmemReady || waitCnt == CW'(MAX_WAIT - 1)) nextState = DONE;
      default: nextState = IDLE;
    endcase
  end

  assign dmemAddr               = {memAluResult[31:2], 2'b00};
  assign dmemWdata              = storeData;
  assign memExecutionData       = memAluResult;
  assign memShouldUseMemoryData = memIsMemRead;

  always_comb begin
    dmemReq             = 1'b0;
    memStall            = 1'b0;
    memRegisterWriteOut = 1'b0;
    memAccessFault      = 1'b0;
    memBusError         = 1'b0;
    memMemoryData       = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (fault) begin
            memAccessFault = 1'b1;
          end else if (issue) begin
            dmemReq  = 1'b1;
            memStall = 1'b1;
          end else begin
            memRegisterWriteOut = memIsRegisterWrite;
          end
        end
        REQ: begin
          dmemReq  = 1'b1;
          memStall = 1'b1;
        end
        default: begin
          memBusError         = errorFlag;
          memRegisterWriteOut = memIsRegisterWrite & ~errorFlag;
          if (memIsMemRead) memMemoryData = loadData;
        end
      endcase
    end
  end

  assign dmemWe         = dmemReq & memIsMemWrite;
  assign dmemByteEnable = (dmemReq & memIsMemWrite) ? storeBe : 4'b0000;

endmodule

// File: tb/tb_memory_access_stage.sv
// tb/tb_memory_access_stage.sv - directed self-checking bench for memory_access_stage
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] memAluResult, memStoreData;
  logic        memIsMemRead, memIsMemWrite;
  logic [2:0]  memFunct3;
  logic        memIsRegisterWrite;
  logic        dmemReq, dmemWe;
  logic [31:0] dmemAddr, dmemWdata;
  logic [3:0]  dmemByteEnable;
  logic        dmemReady;
  logic [31:0] dmemRdata;
  logic        memStall;
  logic [31:0] memMemoryData, memExecutionData;
  logic        memShouldUseMemoryData, memRegisterWriteOut, memAccessFault, memBusError;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  memory_access_stage #(.MAX_WAIT(16)) dut (
    .clk(clk), .reset(reset),
    .memAluResult(memAluResult), .memStoreData(memStoreData),
    .memIsMemRead(memIsMemRead), .memIsMemWrite(memIsMemWrite),
    .memFunct3(memFunct3), .memIsRegisterWrite(memIsRegisterWrite),
    .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr),
    .dmemWdata(dmemWdata), .dmemByteEnable(dmemByteEnable),
    .dmemReady(dmemReady), .dmemRdata(dmemRdata),
    .memStall(memStall), .memMemoryData(memMemoryData),
    .memExecutionData(memExecutionData),
    .memShouldUseMemoryData(memShouldUseMemoryData),
    .memRegisterWriteOut(memRegisterWriteOut),
    .memAccessFault(memAccessFault), .memBusError(memBusError)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data, input logic rw);
    memIsMemRead = rd; memIsMemWrite = wr; memFunct3 = f3;
    memAluResult = addr; memStoreData = data; memIsRegisterWrite = rw;
    #1;
  endtask

  task automatic idle_inputs();
    dmemReady = 1'b0;
    dmemRdata = 32'h0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dmemReady = 1'b0; dmemRdata = 32'h0;
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b1);
    step(); step();
    total++;
    if ({dmemReq, memStall, memRegisterWriteOut, memAccessFault, memBusError} !== 5'b0 || memMemoryData !== 32'h0)
      $display("FAIL reset_outputs: req=%b stall=%b rw=%b flt=%b be=%b data=%h required all zero",
               dmemReq, memStall, memRegisterWriteOut, memAccessFault, memBusError, memMemoryData);
    else passed++;
    reset = 1'b0;
    idle_inputs();
    step();
  endtask

  task automatic test_lw_fast();
    dmemReady = 1'b1; dmemRdata = 32'hDEADBEEF;
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b1);
    total++;
    if (dmemReq !== 1'b1 || memStall !== 1'b1 || memRegisterWriteOut !== 1'b0 || dmemAddr !== 32'h100 || dmemWe !== 1'b0 || dmemByteEnable !== 4'b0000)
      $display("FAIL lw_issue: req=%b stall=%b rw=%b addr=%h we=%b be=%b required 1 1 0 00000100 0 0000",
               dmemReq, memStall, memRegisterWriteOut, dmemAddr, dmemWe, dmemByteEnable);
    else passed++;
    step();
    dmemReady = 1'b0; dmemRdata = 32'h55555555; #1;
    total++;
    if (memStall !== 1'b0 || dmemReq !== 1'b0 || memMemoryData !== 32'hDEADBEEF || memRegisterWriteOut !== 1'b1)
      $display("FAIL lw_done: stall=%b req=%b data=%h rw=%b required 0 0 deadbeef 1",
               memStall, dmemReq, memMemoryData, memRegisterWriteOut);
    else passed++;
    step();
    idle_inputs();
  endtask

  task automatic test_lb_wait();
    dmemReady = 1'b0; dmemRdata = 32'h0;
    drive(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin dmemReady = 1'b1; dmemRdata = 32'h80FF0000; #1; end
      total++;
      if (memStall !== 1'b1 || memRegisterWriteOut !== 1'b0 || dmemAddr !== 32'h100)
        $display("FAIL lb_stall_cycle%0d: stall=%b rw=%b addr=%h required 1 0 00000100",
                 c, memStall, memRegisterWriteOut, dmemAddr);
      else passed++;
      step();
    end
    dmemReady = 1'b0; #1;
    total++;
    if (memMemoryData !== 32'hFFFFFF80 || memRegisterWriteOut !== 1'b1 || memStall !== 1'b0)
      $display("FAIL lb_done: data=%h rw=%b stall=%b required ffffff80 1 0", memMemoryData, memRegisterWriteOut, memStall);
    else passed++;
    step();
    dmemReady = 1'b1; dmemRdata = 32'h80FF0000;
    drive(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1'b1);
    step();
    dmemReady = 1'b0; #1;
    total++;
    if (memMemoryData !== 32'h00000080)
      $display("FAIL lbu_done: data=%h required 00000080", memMemoryData);
    else passed++;
    step();
    dmemReady = 1'b1; dmemRdata = 32'h80FF0000;
    drive(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1'b1);
    step();
    dmemReady = 1'b0; #1;
    total++;
    if (memMemoryData !== 32'hFFFF80FF)
      $display("FAIL lh_done: data=%h required ffff80ff", memMemoryData);
    else passed++;
    step();
    idle_inputs();
  endtask

  task automatic test_store();
    dmemReady = 1'b1;
    drive(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 1'b0);
    total++;
    if (dmemWdata !== 32'hABCDABCD || dmemByteEnable !== 4'b1100 || dmemWe !== 1'b1 || dmemAddr !== 32'h200 || dmemReq !== 1'b1)
      $display("FAIL sh_lanes: wdata=%h be=%b we=%b addr=%h req=%b required abcdabcd 1100 1 00000200 1",
               dmemWdata, dmemByteEnable, dmemWe, dmemAddr, dmemReq);
    else passed++;
    step();
    dmemReady = 1'b0; #1;
    total++;
    if (memStall !== 1'b0 || memMemoryData !== 32'h0 || dmemReq !== 1'b0)
      $display("FAIL sh_done: stall=%b data=%h req=%b required 0 0 0", memStall, memMemoryData, dmemReq);
    else passed++;
    step();
    drive(1'b0, 1'b1, 3'b000, 32'h201, 32'h1234ABCD, 1'b0);
    total++;
    if (dmemWdata !== 32'hCDCDCDCD || dmemByteEnable !== 4'b0010)
      $display("FAIL sb_lanes: wdata=%h be=%b required cdcdcdcd 0010", dmemWdata, dmemByteEnable);
    else passed++;
    dmemReady = 1'b1; #1;
    step(); step();
    idle_inputs();
  endtask

  task automatic test_fault();
    dmemReady = 1'b0;
    drive(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 1'b1);
    total++;
    if (memAccessFault !== 1'b1 || dmemReq !== 1'b0 || memStall !== 1'b0 || memRegisterWriteOut !== 1'b0)
      $display("FAIL lw_misaligned: flt=%b req=%b stall=%b rw=%b required 1 0 0 0",
               memAccessFault, dmemReq, memStall, memRegisterWriteOut);
    else passed++;
    step();
    drive(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 1'b1);
    total++;
    if (memAccessFault !== 1'b1 || dmemReq !== 1'b0 || memStall !== 1'b0 || memRegisterWriteOut !== 1'b0)
      $display("FAIL rd_wr_both: flt=%b req=%b stall=%b rw=%b required 1 0 0 0",
               memAccessFault, dmemReq, memStall, memRegisterWriteOut);
    else passed++;
    step();
    drive(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 1'b0);
    total++;
    if (memAccessFault !== 1'b1 || dmemReq !== 1'b0)
      $display("FAIL store_illegal_f3: flt=%b req=%b required 1 0", memAccessFault, dmemReq);
    else passed++;
    step();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    total++;
    if (memRegisterWriteOut !== 1'b1 || dmemReq !== 1'b0 || memStall !== 1'b0 || memAccessFault !== 1'b0)
      $display("FAIL idle_after_fault: rw=%b req=%b stall=%b flt=%b required 1 0 0 0",
               memRegisterWriteOut, dmemReq, memStall, memAccessFault);
    else passed++;
    step();
    idle_inputs();
  endtask

  task automatic test_timeout();
    int stalls = 0;
    logic rwSeen = 1'b0;
    dmemReady = 1'b0;
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b1);
    while (memStall === 1'b1 && stalls < 40) begin
      if (memRegisterWriteOut !== 1'b0) rwSeen = 1'b1;
      stalls++;
      step();
    end
    total++;
    if (stalls !== 16 || rwSeen !== 1'b0)
      $display("FAIL timeout_stalls: stalls=%0d rw_during_stall=%b required 16 0", stalls, rwSeen);
    else passed++;
    total++;
    if (memBusError !== 1'b1 || memRegisterWriteOut !== 1'b0 || memMemoryData !== 32'h0 || dmemReq !== 1'b0)
      $display("FAIL timeout_done: buserr=%b rw=%b data=%h req=%b required 1 0 0 0",
               memBusError, memRegisterWriteOut, memMemoryData, dmemReq);
    else passed++;
    step();
    idle_inputs();
    total++;
    if (memBusError !== 1'b0 || dmemReq !== 1'b0 || memStall !== 1'b0)
      $display("FAIL timeout_after: buserr=%b req=%b stall=%b required 0 0 0", memBusError, dmemReq, memStall);
    else passed++;
  endtask

  task automatic test_reset_mid();
    dmemReady = 1'b0;
    drive(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 1'b1);
    step(); step();
    reset = 1'b1; #1;
    total++;
    if (dmemReq !== 1'b0 || memStall !== 1'b0)
      $display("FAIL reset_in_req: req=%b stall=%b required 0 0", dmemReq, memStall);
    else passed++;
    step();
    reset = 1'b0;
    dmemReady = 1'b1; dmemRdata = 32'h11223344; #1;
    total++;
    if (dmemReq !== 1'b1 || memStall !== 1'b1)
      $display("FAIL reissue_after_reset: req=%b stall=%b required 1 1", dmemReq, memStall);
    else passed++;
    step();
    dmemReady = 1'b0; #1;
    total++;
    if (memMemoryData !== 32'h11223344 || memRegisterWriteOut !== 1'b1)
      $display("FAIL reissue_done: data=%h rw=%b required 11223344 1", memMemoryData, memRegisterWriteOut);
    else passed++;
    step();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_lw_fast();
    test_lb_wait();
    test_store();
    test_fault();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
